uart_frame_arbiter: RTL and testbench

//  Shares the single UART byte transmitter between two 32-bit word sources (req0 = CPU, req1 = FPGA).

---
 rtl/morty_uart_pkg.sv | 19 +
 rtl/uart_frame_arbiter_if.sv | 22 ++
 rtl/uart_frame_arbiter_rr_arb2.sv | 11 +
 rtl/uart_frame_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_frame_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/morty_uart_pkg.sv
// Shared definitions for the UART frame arbiter: FSM state encoding, default
// frame headers and frame geometry.
package morty_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    localparam logic [7:0] HDR0_DEF    = 8'hA5;
    localparam logic [7:0] HDR1_DEF    = 8'h5A;
    localparam int         FRAME_BYTES = 6;

    // Header and checksum bracket the payload; the rest are data bytes.
    localparam logic [1:0] LAST_DATA_IDX = 2'(FRAME_BYTES - 3);

endpackage

// File: rtl/uart_frame_arbiter_if.sv
// Word-source and byte-transmitter handshakes seen by the frame arbiter.
interface uart_frame_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_ready,
        output req0_ready, req1_ready, tx_byte, tx_valid
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_ready,
        input  req0_ready, req1_ready, tx_byte, tx_valid
    );
endinterface

// File: rtl/uart_frame_arbiter_rr_arb2.sv
// Two-way round-robin picker; the source not served last wins a tie.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt,
    output logic gnt_id
);
    assign gnt    = valid0 | valid1;
    assign gnt_id = (valid0 & valid1) ? ~last_grant : valid1;
endmodule

// File: rtl/uart_frame_arbiter.sv
// Frames 32-bit words from two sources into 6-byte UART frames
// (header, 4 data bytes MSB first, XOR checksum) with a stall watchdog.
//
//  state   | meaning
//  IDLE    | no frame in flight; grant a waiting source this cycle
//  HDR     | presenting the header byte
//  DATA    | presenting data byte byte_idx (0 = bits 31:24)
//  CSUM    | presenting the checksum byte
module uart_frame_arbiter
    import morty_uart_pkg::*;
#(
    parameter logic [7:0] HDR0        = HDR0_DEF,
    parameter logic [7:0] HDR1        = HDR1_DEF,
    parameter int         TIMEOUT_CYC = 1024,
    parameter int         CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_frame_arbiter_if.slave  bus,
    output logic                 grant_id,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int             WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    state_t          state, state_nx;
    logic [31:0]     word;
    logic [1:0]      byte_idx;
    logic [7:0]      csum;
    logic            last_grant;
    logic [WD_W-1:0] wd_cnt;
    logic            tx_valid_q;

    logic            gnt, gnt_id;
    logic            take, accept, stall_out, csum_accept;
    logic [7:0]      cur_byte;

    rr_arb2 u_arb (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant),
        .gnt        (gnt),
        .gnt_id     (gnt_id)
    );

    // Gate with reset so ready stays low while reset is held.
    assign take           = (state == ST_IDLE) & gnt & ~reset;
    assign bus.req0_ready = take & ~gnt_id;
    assign bus.req1_ready = take & gnt_id;

    assign accept      = tx_valid_q & bus.tx_ready;
    assign stall_out   = tx_valid_q & ~bus.tx_ready & (wd_cnt == WD_LAST);
    assign csum_accept = (state == ST_CSUM) & accept;

    always_comb begin
        cur_byte = 8'h00;
        case (state)
            ST_HDR:  cur_byte = grant_id ? HDR1 : HDR0;
            ST_DATA: begin
                case (byte_idx)
                    2'd0:    cur_byte = word[31:24];
                    2'd1:    cur_byte = word[23:16];
                    2'd2:    cur_byte = word[15:8];
                    default: cur_byte = word[7:0];
                endcase
            end
            ST_CSUM: cur_byte = csum;
            default: cur_byte = 8'h00;
        endcase
    end

    assign bus.tx_byte  = cur_byte;
    assign bus.tx_valid = tx_valid_q;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (take) state_nx = ST_HDR;
            ST_HDR:  if (accept) state_nx = ST_DATA;
            ST_DATA: if (accept && byte_idx == LAST_DATA_IDX) state_nx = ST_CSUM;
            ST_CSUM: if (accept) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (stall_out) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            tx_valid_q  <= 1'b0;
            word        <= 32'h0;
            byte_idx    <= 2'd0;
            csum        <= 8'h00;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            wd_cnt      <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nx;
            tx_valid_q  <= (state_nx != ST_IDLE);
            frame_done  <= csum_accept;
            timeout_err <= stall_out;
            if (csum_accept) frame_cnt <= frame_cnt + 1'b1;

            if (state == ST_IDLE || accept || stall_out)
                wd_cnt <= '0;
            else if (tx_valid_q)
                wd_cnt <= wd_cnt + 1'b1;

            // Checksum starts at the header and folds in each data byte as it leaves.
            if (take) begin
                word       <= gnt_id ? bus.req1_data : bus.req0_data;
                grant_id   <= gnt_id;
                last_grant <= gnt_id;
                csum       <= gnt_id ? HDR1 : HDR0;
                byte_idx   <= 2'd0;
            end else if (accept && state == ST_DATA) begin
                csum     <= csum ^ cur_byte;
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: a queue-based frame model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_uart_frame_arbiter;

    localparam int TMO   = 1024;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    logic grant_id, busy, frame_done, timeout_err;
    logic [CNT_W-1:0] frame_cnt;

    uart_frame_arbiter_if ifc ();

    uart_frame_arbiter #(.HDR0(8'hA5), .HDR1(8'h5A), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifc),
        .grant_id    (grant_id),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    int  m_stall;
    bit  m_last, m_gid, m_done, m_tout;
    int  m_cnt;

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_stall = 0; m_last = 1'b1; m_gid = 1'b0;
            m_done = 1'b0; m_tout = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            m_tout = 1'b0;
            if (mq.size() == 0) begin
                if (ifc.req0_valid || ifc.req1_valid) begin
                    bit w;
                    logic [31:0] d;
                    logic [7:0] h;
                    w = pick(ifc.req0_valid, ifc.req1_valid, m_last);
                    d = w ? ifc.req1_data : ifc.req0_data;
                    h = w ? 8'h5A : 8'hA5;
                    mq.push_back(h);
                    mq.push_back(d[31:24]);
                    mq.push_back(d[23:16]);
                    mq.push_back(d[15:8]);
                    mq.push_back(d[7:0]);
                    mq.push_back(h ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
                    m_gid = w; m_last = w; m_stall = 0;
                end
            end else if (ifc.tx_ready) begin
                void'(mq.pop_front());
                m_stall = 0;
                if (mq.size() == 0) begin
                    m_done = 1'b1;
                    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
                end
            end else begin
                m_stall++;
                if (m_stall == TMO) begin
                    mq.delete();
                    m_tout  = 1'b1;
                    m_stall = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit ev, idle_grant, w;
        ev = (mq.size() != 0);
        idle_grant = !reset && !ev && (ifc.req0_valid || ifc.req1_valid);
        w = pick(ifc.req0_valid, ifc.req1_valid, m_last);
        check("tx_valid", ifc.tx_valid, ev);
        if (ev) check("tx_byte", ifc.tx_byte, mq[0]);
        check("busy", busy, ev);
        check("grant_id", grant_id, m_gid);
        check("req0_ready", ifc.req0_ready, idle_grant && !w);
        check("req1_ready", ifc.req1_ready, idle_grant && w);
        check("frame_done", frame_done, m_done);
        check("timeout_err", timeout_err, m_tout);
        check("frame_cnt", frame_cnt, m_cnt[CNT_W-1:0]);
    end

    // ---------------- observation logs ----------------
    logic [7:0] byte_log[$];
    bit         grant_log[$];
    int         cnt_log[$];
    int         n_done, n_tout, n_tv;

    always @(negedge clk) begin
        if (ifc.tx_valid && ifc.tx_ready) byte_log.push_back(ifc.tx_byte);
        if (ifc.req0_ready) grant_log.push_back(1'b0);
        if (ifc.req1_ready) grant_log.push_back(1'b1);
        if (frame_done) begin n_done++; cnt_log.push_back(int'(frame_cnt)); end
        if (timeout_err) n_tout++;
        if (ifc.tx_valid) n_tv++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit src, input logic [31:0] d);
        if (src) begin ifc.req1_valid = 1'b1; ifc.req1_data = d; end
        else     begin ifc.req0_valid = 1'b1; ifc.req0_data = d; end
        tick(1);
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [47:0] exp);
        logic [47:0] e;
        e = exp;
        check({name, "_len"}, byte_log.size(), 6);
        for (int i = 0; i < 6; i++)
            check(name, (i < byte_log.size()) ? byte_log[i] : 8'hxx, e[47-8*i -: 8]);
    endtask

    initial begin
        reset = 1'b1;
        ifc.req0_valid = 1'b0; ifc.req0_data = 32'h0;
        ifc.req1_valid = 1'b0; ifc.req1_data = 32'h0;
        ifc.tx_ready = 1'b0;
        tick(3);
        check("rst_tx_valid", ifc.tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_grant_id", grant_id, 0);
        reset = 1'b0;
        tick(2);

        // 1: single req0 frame
        ifc.tx_ready = 1'b1;
        byte_log.delete(); n_done = 0;
        send(1'b0, 32'h11223344);
        tick(8);
        check_frame("t1_bytes", 48'hA5_11_22_33_44_E1);
        check("t1_done_cnt", n_done, 1);
        check("t1_frame_cnt", frame_cnt, 1);

        // 2: both valid continuously; last winner was req0, so req1 goes first
        grant_log.delete();
        ifc.req0_valid = 1'b1; ifc.req0_data = 32'hA0A1A2A3;
        ifc.req1_valid = 1'b1; ifc.req1_data = 32'hB0B1B2B3;
        tick(28);
        ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
        tick(10);
        check("t2_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t2_grant_order", (i < grant_log.size()) ? grant_log[i] : 1'bx, (i % 2 == 0) ? 1 : 0);
        check("t2_frame_cnt", frame_cnt, 5);

        // 3: tx_ready toggling every cycle
        byte_log.delete(); n_tout = 0;
        ifc.tx_ready = 1'b1;
        send(1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 20; i++) begin
            ifc.tx_ready = ~ifc.tx_ready;
            tick(1);
        end
        ifc.tx_ready = 1'b1;
        tick(4);
        check_frame("t3_bytes", 48'h5A_DE_AD_BE_EF_78);
        check("t3_no_timeout", n_tout, 0);
        check("t3_frame_cnt", frame_cnt, 6);

        // 4: watchdog abort after TMO stalled cycles
        ifc.tx_ready = 1'b0;
        n_tv = 0; n_tout = 0; n_done = 0;
        send(1'b0, 32'h55667788);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < TMO + 100 && !seen; i++) begin
                @(negedge clk); #1;
                if (n_tout != 0) seen = 1'b1;
            end
            check("t4_timeout_seen", seen, 1);
            check("t4_tx_valid_low", ifc.tx_valid, 0);
            check("t4_busy_low", busy, 0);
            check("t4_valid_cycles", n_tv, TMO);
        end
        tick(3);
        check("t4_tout_pulses", n_tout, 1);
        check("t4_no_done", n_done, 0);
        check("t4_frame_cnt", frame_cnt, 6);

        // 5: reset during data byte 2
        ifc.tx_ready = 1'b1;
        send(1'b0, 32'h01020304);
        tick(3);
        reset = 1'b1;
        #1;
        check("t5_tx_valid", ifc.tx_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_frame_cnt", frame_cnt, 0);
        check("t5_frame_done", frame_done, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        byte_log.delete();
        send(1'b0, 32'hCAFEF00D);
        tick(8);
        check_frame("t5_bytes", 48'hA5_CA_FE_F0_0D_6C);
        check("t5_frame_cnt_after", frame_cnt, 1);

        // 6: frame counter wrap
        cnt_log.delete();
        for (int i = 0; i < 15; i++) begin
            send(1'b0, 32'h01010101 * (i + 1));
            tick(7);
        end
        tick(2);
        check("t6_done_pulses", cnt_log.size(), 15);
        check("t6_cnt_before_wrap", (cnt_log.size() >= 14) ? cnt_log[13] : -1, 15);
        check("t6_cnt_wrapped", (cnt_log.size() >= 15) ? cnt_log[14] : -1, 0);
        check("t6_frame_cnt", frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
